// File: rtl/serial_bus_master_p.sv
// serial_bus_master_p: parametrised serial bus master.
// Takes one read or write command from the user side and requests the shared bus.
// It then sends a slave-select prefix of SEL_W address MSBs and waits for the slave.
// The wait is bounded and the prefix is retried a bounded number of times.
// After that it shifts out the rest of the address and the write data MSB-first,
// or shifts in the read data.
//
// Ports:
//   clock, reset_n      clock (posedge) and async active-low reset
//   start, read_en      command request and direction (1 = read), sampled together
//   addr_in, data_in    command address and write data, sampled with start
//   bus_grant           arbiter grant
//   slave_ready         slave acknowledges prefix (only looked at in ACKWAIT)
//   slave_valid         read data starts next cycle (only looked at in RWAIT)
//   data_rx             serial read data, MSB-first
//   bus_req, valid      bus request / request-valid to arbiter
//   valid_s             frame-valid to slave
//   write_en_slave      ~read_en of the latched command
//   addr_tx, data_tx    serial address / write data lines
//   busy, done, err     status; err is held until the next accepted command
//   data_read           last successfully read word
//
// Build option: define SBM_PARITY_EN to append an even-parity bit to every data frame.
module serial_bus_master_p #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              bus_grant,
  input  logic              slave_ready,
  input  logic              slave_valid,
  input  logic              data_rx,
  output logic              bus_req,
  output logic              valid,
  output logic              valid_s,
  output logic              write_en_slave,
  output logic              addr_tx,
  output logic              data_tx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] data_read
);

`ifdef SBM_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  localparam int unsigned FrameW = DATA_W + ParBits;
  localparam int unsigned CntMax = (ADDR_W > FrameW) ? ADDR_W : FrameW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    StIdle, StReq, StPrefix, StAckWait, StAddr, StWData, StRWait, StRData, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic [FrameW-1:0]   tx_sh_q, tx_sh_d;
  logic [FrameW-1:0]   rx_sh_q, rx_sh_d;
  logic                rd_q, rd_d;
  logic                bus_req_q, bus_req_d;
  logic                valid_q, valid_d;
  logic                valid_s_q, valid_s_d;
  logic                we_q, we_d;
  logic                addr_tx_q, addr_tx_d;
  logic                data_tx_q, data_tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_read_q, data_read_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    addr_lat_d  = addr_lat_q;
    addr_sh_d   = addr_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rd_d        = rd_q;
    we_d        = we_q;
    err_d       = err_q;
    data_read_d = data_read_q;

    unique case (state_q)
      StIdle: begin
        if (start && !busy_q) begin
          addr_lat_d = addr_in;
          addr_sh_d  = addr_in;
`ifdef SBM_PARITY_EN
          tx_sh_d    = {data_in, ^data_in};
`else
          tx_sh_d    = data_in;
`endif
          rd_d       = read_en;
          we_d       = ~read_en;
          err_d      = 1'b0;
          retry_d    = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (bus_grant) begin
          cnt_d   = '0;
          state_d = StPrefix;
        end
      end
      StPrefix: begin
        // Shifter MSB is always the bit on the wire this cycle.
        addr_sh_d = addr_sh_q << 1;
        if (cnt_q == CntW'(SEL_W - 1)) begin
          cnt_d   = '0;
          wait_d  = '0;
          state_d = StAckWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAckWait: begin
        if (slave_ready) begin
          cnt_d   = '0;
          state_d = StAddr;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d   = retry_q + RetryW'(1);
            addr_sh_d = addr_lat_q;
            cnt_d     = '0;
            state_d   = StPrefix;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StAddr: begin
        addr_sh_d = addr_sh_q << 1;
        if (cnt_q == CntW'(ADDR_W - SEL_W - 1)) begin
          cnt_d  = '0;
          wait_d = '0;
          state_d = rd_q ? StRWait : StWData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWData: begin
        tx_sh_d = tx_sh_q << 1;
        if (cnt_q == CntW'(FrameW - 1)) state_d = StDone;
        else                            cnt_d   = cnt_q + CntW'(1);
      end
      StRWait: begin
        if (slave_valid) begin
          cnt_d   = '0;
          state_d = StRData;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRData: begin
        rx_sh_d = (rx_sh_q << 1) | FrameW'(data_rx);
        if (cnt_q == CntW'(FrameW - 1)) begin
          state_d = StDone;
`ifdef SBM_PARITY_EN
          // Data plus its even-parity bit must XOR to zero.
          if (^rx_sh_d) err_d       = 1'b1;
          else          data_read_d = rx_sh_d[FrameW-1 -: DATA_W];
`else
          data_read_d = rx_sh_d;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    valid_d   = (state_d == StReq);
    bus_req_d = !(state_d inside {StIdle, StDone});
    valid_s_d = !(state_d inside {StIdle, StReq, StDone});
    addr_tx_d = (state_d inside {StPrefix, StAddr}) && addr_sh_d[ADDR_W-1];
    data_tx_d = (state_d == StWData) && tx_sh_d[FrameW-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wait_q      <= '0;
      retry_q     <= '0;
      addr_lat_q  <= '0;
      addr_sh_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      bus_req_q   <= 1'b0;
      valid_q     <= 1'b0;
      valid_s_q   <= 1'b0;
      addr_tx_q   <= 1'b0;
      data_tx_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_read_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      addr_lat_q  <= addr_lat_d;
      addr_sh_q   <= addr_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      bus_req_q   <= bus_req_d;
      valid_q     <= valid_d;
      valid_s_q   <= valid_s_d;
      addr_tx_q   <= addr_tx_d;
      data_tx_q   <= data_tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      data_read_q <= data_read_d;
    end
  end

  assign bus_req        = bus_req_q;
  assign valid          = valid_q;
  assign valid_s        = valid_s_q;
  assign write_en_slave = we_q;
  assign addr_tx        = addr_tx_q;
  assign data_tx        = data_tx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign data_read      = data_read_q;

endmodule

// File: tb/tb_serial_bus_master_p.sv
// Self-checking bench for serial_bus_master_p (default parameters).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_serial_bus_master_p;
  localparam int A = 14;
  localparam int D = 8;
  localparam int S = 2;
  localparam int T = 16;
  localparam int R = 3;
`ifdef SBM_PARITY_EN
  localparam int FW = D + 1;
`else
  localparam int FW = D;
`endif

  logic         clock;
  logic         reset_n;
  logic         start, read_en, bus_grant, slave_ready, slave_valid, data_rx;
  logic [A-1:0] addr_in;
  logic [D-1:0] data_in;
  logic         bus_req, valid, valid_s, write_en_slave, addr_tx, data_tx;
  logic         busy, done, err;
  logic [D-1:0] data_read;

  typedef struct {
    logic         err;
    logic [D-1:0] dr;
    int           lat;
    int           ones;
  } sb_item_t;

  sb_item_t     sb_q[$];
  logic [D-1:0] mdl_dr;
  int           n_checks;
  int           n_fail;

  serial_bus_master_p #(
    .ADDR_W(A), .DATA_W(D), .SEL_W(S), .TIMEOUT(T), .MAX_RETRY(R)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .read_en(read_en),
    .addr_in(addr_in), .data_in(data_in), .bus_grant(bus_grant),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx(data_rx),
    .bus_req(bus_req), .valid(valid), .valid_s(valid_s),
    .write_en_slave(write_en_slave), .addr_tx(addr_tx), .data_tx(data_tx),
    .busy(busy), .done(done), .err(err), .data_read(data_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command. Timing inputs are cycle offsets k after the accept edge:
  // grant_at: grant raised (then dropped 2 cycles later); ack_at: slave_ready held high from here
  // (-1 never); sv_at: slave_valid pulse (-1 never), read bits follow; spur_at: extra start pulse.
  task automatic run_cmd(input bit rd, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                         input logic [D-1:0] rx_word, input bit rx_par, input int grant_at,
                         input int ack_at, input int sv_at, input int spur_at,
                         input bit chk_stream, input int exp_lat, input bit exp_err,
                         input int exp_ones);
    sb_item_t      item;
    sb_item_t      got;
    logic [A-1:0]  got_addr;
    logic [FW-1:0] got_data, wframe, rxf;
    int            cyc, ones, j;
    bit            seen;
`ifdef SBM_PARITY_EN
    wframe = {wdata, ^wdata};
    rxf    = {rx_word, rx_par};
`else
    wframe = wdata;
    rxf    = rx_word;
`endif
    item.err  = exp_err;
    item.dr   = (rd && !exp_err) ? rx_word : mdl_dr;
    item.lat  = exp_lat;
    item.ones = exp_ones;
    mdl_dr    = item.dr;
    sb_q.push_back(item);

    start = 1'b1; read_en = rd; addr_in = addr; data_in = wdata;
    bus_grant = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; data_rx = 1'b0;
    @(posedge clock); #1;
    cyc = 0; ones = 0; seen = 0; got_addr = '0; got_data = '0;
    for (int k = 0; k < 400 && !seen; k++) begin
      start       = (k == spur_at);
      read_en     = (k == spur_at) ? !rd : rd;
      bus_grant   = (k >= grant_at) && (k < grant_at + 2);
      slave_ready = (ack_at >= 0) && (k >= ack_at);
      slave_valid = (k == sv_at);
      data_rx     = 1'b0;
      if (sv_at >= 0 && k > sv_at && k <= sv_at + FW) data_rx = rxf[FW - (k - sv_at)];
      @(negedge clock);
      j = k - grant_at;
      if (busy) cyc++;
      ones += int'(addr_tx);
      if (k == 0) check_eq("we_slave", write_en_slave, !rd);
      if (j <= 0) check_eq("valid_in_req", {valid, bus_req, busy}, 3'b111);
      if (j == 1) check_eq("frame_start", {valid, valid_s}, 2'b01);
      if (chk_stream) begin
        if ((j >= 1 && j <= S) || (j >= S + 2 && j <= A + 1))
          got_addr = {got_addr[A-2:0], addr_tx};
        if (j >= A + 2 && j <= A + 1 + FW) got_data = {got_data[FW-2:0], data_tx};
      end
      if (done) begin
        seen = 1;
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", 1, 0);
        end else begin
          got = sb_q.pop_front();
          check_eq("err", err, got.err);
          check_eq("data_read", data_read, got.dr);
          check_eq("latency", cyc, got.lat);
          check_eq("addr_ones", ones, got.ones);
          check_eq("done_frame", {bus_req, valid_s, busy}, 3'b001);
        end
      end else begin
        @(posedge clock); #1;
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
      if (sb_q.size() > 0) got = sb_q.pop_front();
    end else begin
      if (chk_stream) begin
        check_eq("addr_stream", got_addr, addr);
        check_eq("data_stream", got_data, rd ? '0 : wframe);
      end
      @(posedge clock); #1;
      @(negedge clock);
      check_eq("idle_after_done", {busy, done, bus_req}, 3'b000);
      check_eq("err_held", err, exp_err);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [A-1:0] ad;
    bit           perr;
    n_checks = 0; n_fail = 0; mdl_dr = '0;
    reset_n = 1'b0; start = 1'b0; read_en = 1'b0; addr_in = '0; data_in = '0;
    bus_grant = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; data_rx = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_eq("reset_outs", {bus_req, valid, valid_s, write_en_slave, addr_tx, data_tx,
                               busy, done, err, data_read}, '0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Zero-wait write.
    ad = 14'h2A5C;
    run_cmd(0, ad, 8'hA7, 8'h00, 0, 0, 0, -1, -1, 1,
            1 + S + 1 + (A - S) + FW + 1, 0, $countones(ad));
    // Read, slave_valid three cycles into RWAIT.
    ad = 14'h0013;
    run_cmd(1, ad, 8'h00, 8'h5E, ^8'h5E, 0, 0, 18, -1, 1, 18 + FW + 2, 0, $countones(ad));
    // Slave never answers: prefix sent 1+R times, then err.
    ad = 14'h3123;
    run_cmd(0, ad, 8'h11, 8'h00, 0, 0, -1, -1, -1, 0,
            1 + (1 + R) * (S + T) + 1, 1, (1 + R) * $countones(ad[A-1:A-S]));
    // Slave answers on the second attempt.
    ad = 14'h2A5C;
    run_cmd(0, ad, 8'h3C, 8'h00, 0, 0, 20, -1, -1, 0,
            1 + S + 1 + (A - S) + FW + 1 + S + T, 0, $countones(ad) + $countones(ad[A-1:A-S]));
    // Read data never arrives.
    ad = 14'h1555;
    run_cmd(1, ad, 8'h00, 8'h00, 0, 0, 0, -1, -1, 0,
            1 + S + 1 + (A - S) + T + 1, 1, $countones(ad));
    // Late grant, then a read.
    ad = 14'h3ABC;
    run_cmd(1, ad, 8'h00, 8'hC3, ^8'hC3, 4, 0, 22, -1, 1, 22 + FW + 2, 0, $countones(ad));

    // Asynchronous reset in the middle of the address phase.
    start = 1'b1; read_en = 1'b0; addr_in = 14'h1FFF; data_in = 8'hFF;
    bus_grant = 1'b1; slave_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_eq("reset_mid_addr", {bus_req, valid, valid_s, write_en_slave, addr_tx, data_tx,
                                   busy, done, err, data_read}, '0);
    mdl_dr = '0;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Normal write after reset, with a start pulse while busy.
    ad = 14'h1234;
    run_cmd(0, ad, 8'h5A, 8'h00, 0, 0, 0, -1, 5, 1,
            1 + S + 1 + (A - S) + FW + 1, 0, $countones(ad));

`ifdef SBM_PARITY_EN
    ad = 14'h0A0A;
    perr = 1'b1 ^ (^8'h81);
    run_cmd(1, ad, 8'h00, 8'h81, 1'b1, 0, 0, 18, -1, 0, 18 + FW + 2, perr, $countones(ad));
    perr = 1'b0 ^ (^8'h81);
    run_cmd(1, ad, 8'h00, 8'h81, 1'b0, 0, 0, 18, -1, 0, 18 + FW + 2, perr, $countones(ad));
`else
    perr = 1'b0;
    ad = 14'h0A0A;
    run_cmd(1, ad, 8'h00, 8'h81, 1'b1, 0, 0, 18, -1, 0, 18 + FW + 2, perr, $countones(ad));
`endif

    check_eq("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
